// File: rtl/switch_pkg.sv
// Shared switchcore types and constants: frame limits, CRC constants,
// the RX descriptor record and the RX FSM state encoding.
package switch_pkg;

    localparam int unsigned LEN_W = 11;
    typedef logic [LEN_W-1:0] len_t;

    localparam len_t        MIN_FRAME_LEN = len_t'(64);
    localparam len_t        MAX_FRAME_LEN = len_t'(1518);
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        len_t        len;
    } rx_desc_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_DATA,
        RX_FCS,
        RX_CHECK,
        RX_DISCARD
    } rx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step over one byte, reflected form, LSB first.
module crc32_d8
    import switch_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h000000, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rx_port_buffer.sv
// Per-lane receive front end: validates CRC and length, commits good frames
// to a local byte buffer with a descriptor, and serves them through a pull port.
module rx_port_buffer
    import switch_pkg::*;
#(
    parameter int unsigned P_BUF_ADDR_WIDTH = 11,
    parameter int unsigned P_DESC_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        link_sync,
    input  logic [7:0]  rx_data,
    input  logic        rx_ctrl,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [47:0] hdr_dst_mac,
    output logic [47:0] hdr_src_mac,
    output logic [10:0] hdr_len,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic [15:0] drop_fcs_cnt,
    output logic [15:0] drop_len_cnt,
    output logic [15:0] drop_ovf_cnt
);

    localparam int unsigned AW = P_BUF_ADDR_WIDTH;
    localparam int unsigned DW = $clog2(P_DESC_DEPTH);
    typedef logic [AW:0] ptr_t;

    rx_state_e   state_q, state_d;
    ptr_t        wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0] crc_q, crc_d, crc_in, crc_next;
    len_t        len_q, len_d, byte_idx;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic [47:0] dst_q, dst_d, src_q, src_d;
    logic        rx_ctrl_prev_q, rx_ctrl_prev_d;
    logic [15:0] drop_fcs_q, drop_fcs_d, drop_len_q, drop_len_d, drop_ovf_q, drop_ovf_d;
    logic        take, wr_en, push, buf_full, len_ok, crc_ok;

    logic [DW:0] desc_wr_q, desc_wr_d, desc_rd_q, desc_rd_d;
    logic        desc_full, desc_empty, pop;
    rx_desc_t    desc_mem [P_DESC_DEPTH];
    rx_desc_t    head_desc;

    len_t        rem_q, rem_d, cur_rem;
    logic        armed, rd_fire, rd_last_q, rd_last_d;
    logic [7:0]  rd_data_q;
    logic [7:0]  buf_mem [2**AW];

    assign buf_full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign desc_empty = (desc_wr_q == desc_rd_q);
    assign desc_full  = (desc_wr_q[DW-1:0] == desc_rd_q[DW-1:0]) && (desc_wr_q[DW] != desc_rd_q[DW]);
    assign len_ok     = (len_q >= MIN_FRAME_LEN) && (len_q <= MAX_FRAME_LEN);
    assign crc_ok     = (crc_q == CRC_RESIDUE);
    assign crc_in     = (state_q == RX_IDLE) ? '1 : crc_q;
    assign byte_idx   = (state_q == RX_IDLE) ? '0 : len_q;

    crc32_d8 u_crc (
        .crc_in  (crc_in),
        .data    (rx_data),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        crc_d        = crc_q;
        len_d        = len_q;
        fcs_idx_d    = fcs_idx_q;
        dst_d        = dst_q;
        src_d        = src_q;
        drop_fcs_d   = drop_fcs_q;
        drop_len_d   = drop_len_q;
        drop_ovf_d   = drop_ovf_q;
        take         = 1'b0;
        push         = 1'b0;
        // Held high while unsynchronised so a frame already in progress
        // cannot masquerade as a new start once the lane comes back.
        rx_ctrl_prev_d = link_sync ? rx_ctrl : 1'b1;

        case (state_q)
            RX_IDLE: begin
                if (link_sync && rx_ctrl && !rx_ctrl_prev_q) begin
                    if (buf_full) begin
                        drop_ovf_d = sat_inc16(drop_ovf_q);
                        state_d    = RX_DISCARD;
                    end else begin
                        take    = 1'b1;
                        state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (!link_sync) begin
                    wr_ptr_d = commit_ptr_q;
                    state_d  = RX_DISCARD;
                end else if (buf_full) begin
                    wr_ptr_d   = commit_ptr_q;
                    drop_ovf_d = sat_inc16(drop_ovf_q);
                    state_d    = RX_DISCARD;
                end else begin
                    take = 1'b1;
                    if (!rx_ctrl) begin
                        fcs_idx_d = 2'd1;
                        state_d   = RX_FCS;
                    end
                end
            end
            RX_FCS: begin
                if (!link_sync) begin
                    wr_ptr_d = commit_ptr_q;
                    state_d  = RX_DISCARD;
                end else if (rx_ctrl) begin
                    wr_ptr_d   = commit_ptr_q;
                    drop_len_d = sat_inc16(drop_len_q);
                    state_d    = RX_DISCARD;
                end else if (buf_full) begin
                    wr_ptr_d   = commit_ptr_q;
                    drop_ovf_d = sat_inc16(drop_ovf_q);
                    state_d    = RX_DISCARD;
                end else begin
                    take      = 1'b1;
                    fcs_idx_d = fcs_idx_q + 2'd1;
                    if (fcs_idx_q == 2'd3) state_d = RX_CHECK;
                end
            end
            RX_CHECK: begin
                state_d = RX_IDLE;
                if (len_ok && crc_ok && !desc_full) begin
                    commit_ptr_d = wr_ptr_q;
                    push         = 1'b1;
                end else begin
                    wr_ptr_d = commit_ptr_q;
                    if (!len_ok)      drop_len_d = sat_inc16(drop_len_q);
                    else if (!crc_ok) drop_fcs_d = sat_inc16(drop_fcs_q);
                    else              drop_ovf_d = sat_inc16(drop_ovf_q);
                end
            end
            RX_DISCARD: begin
                if (!rx_ctrl) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase

        wr_en = take;
        if (take) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
            crc_d    = crc_next;
            len_d    = (state_q == RX_IDLE) ? len_t'(1) :
                       ((len_q == '1) ? len_q : len_q + len_t'(1));
            if (byte_idx < len_t'(6))       dst_d = {dst_q[39:0], rx_data};
            else if (byte_idx < len_t'(12)) src_d = {src_q[39:0], rx_data};
        end
    end

    // Read side. Accepting a new descriptor while the previous frame is still
    // partly unread abandons its tail, so rd_ptr always lands on a frame start.
    assign pop       = hdr_valid && hdr_ready;
    assign armed     = (rem_q != '0);
    assign cur_rem   = armed ? rem_q : hdr_len;
    assign rd_fire   = rd_en && (armed || pop);

    always_comb begin
        rd_last_d = rd_fire && (cur_rem == len_t'(1));
        desc_wr_d = desc_wr_q + {{DW{1'b0}}, push};
        desc_rd_d = desc_rd_q + {{DW{1'b0}}, pop};
        if (pop && armed) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(rem_q);
            rem_d    = hdr_len;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(rd_fire);
            rem_d    = hdr_len - len_t'(rd_fire);
        end else begin
            rd_ptr_d = rd_ptr_q + ptr_t'(rd_fire);
            rem_d    = rem_q - len_t'(rd_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RX_IDLE;
            wr_ptr_q       <= '0;
            commit_ptr_q   <= '0;
            rd_ptr_q       <= '0;
            crc_q          <= '1;
            len_q          <= '0;
            fcs_idx_q      <= '0;
            dst_q          <= '0;
            src_q          <= '0;
            rx_ctrl_prev_q <= 1'b1;
            drop_fcs_q     <= '0;
            drop_len_q     <= '0;
            drop_ovf_q     <= '0;
            desc_wr_q      <= '0;
            desc_rd_q      <= '0;
            rem_q          <= '0;
            rd_last_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            commit_ptr_q   <= commit_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            crc_q          <= crc_d;
            len_q          <= len_d;
            fcs_idx_q      <= fcs_idx_d;
            dst_q          <= dst_d;
            src_q          <= src_d;
            rx_ctrl_prev_q <= rx_ctrl_prev_d;
            drop_fcs_q     <= drop_fcs_d;
            drop_len_q     <= drop_len_d;
            drop_ovf_q     <= drop_ovf_d;
            desc_wr_q      <= desc_wr_d;
            desc_rd_q      <= desc_rd_d;
            rem_q          <= rem_d;
            rd_last_q      <= rd_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[wr_ptr_q[AW-1:0]] <= rx_data;
        if (push)  desc_mem[desc_wr_q[DW-1:0]] <= '{dst: dst_q, src: src_q, len: len_q};
    end

    always_ff @(posedge clk) begin
        if (reset)        rd_data_q <= '0;
        else if (rd_fire) rd_data_q <= buf_mem[rd_ptr_q[AW-1:0]];
    end

    assign head_desc    = desc_mem[desc_rd_q[DW-1:0]];
    assign hdr_valid    = !desc_empty;
    assign hdr_dst_mac  = head_desc.dst;
    assign hdr_src_mac  = head_desc.src;
    assign hdr_len      = head_desc.len;
    assign rd_data      = rd_data_q;
    assign rd_last      = rd_last_q;
    assign drop_fcs_cnt = drop_fcs_q;
    assign drop_len_cnt = drop_len_q;
    assign drop_ovf_cnt = drop_ovf_q;

endmodule

// File: doc/rx_port_buffer.md
# rx_port_buffer

Per-port receive front end for the 4-port switchcore, one instance per lane. It takes a lane's 8-bit `rx_data`/`rx_ctrl` byte stream and checks CRC-32 and frame length. Good frames are committed to a local byte buffer with a header descriptor: destination MAC, source MAC and length. Bad, aborted or overflowing frames are discarded with no trace in the buffer. The switching fabric and MAC table pop descriptors and read frame bytes through a simple pull interface.

## Interface
Parameters:
- `P_BUF_ADDR_WIDTH`, 11: frame buffer holds 2**N bytes.
- `P_DESC_DEPTH`, 4: descriptor FIFO entries; must be a power of two.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  synchronous, active-high.
- `link_sync`  in  1  lane synchronised; while low, RX input is ignored.
- `rx_data`  in  8  lane byte.
- `rx_ctrl`  in  1  high for frame bytes 0..len-5; low for the 4 FCS bytes and the idle gap.
- `hdr_valid`  out  1  a committed descriptor is available.
- `hdr_ready`  in  1  consumer accepts the descriptor.
- `hdr_dst_mac`  out  48  frame bytes 0..5; byte 0 in [47:40].
- `hdr_src_mac`  out  48  frame bytes 6..11; byte 6 in [47:40].
- `hdr_len`  out  11  frame length in bytes, FCS included.
- `rd_en`  in  1  request the next byte of the accepted frame.
- `rd_data`  out  8  frame byte.
- `rd_last`  out  1  marks the final byte (the FCS byte).
- `drop_fcs_cnt`, `drop_len_cnt`, `drop_ovf_cnt`  out  16 each  saturating drop counters.

## Operation
- RX FSM states: IDLE, DATA, FCS, CHECK, DISCARD.
- IDLE → DATA when `link_sync`=1 and `rx_ctrl` rises from 0 to 1. The byte on that cycle is byte 0.
- DATA: each byte is written at `wr_ptr` and fed to the CRC. The length counter is 11-bit and saturates at 2047.
- DATA → FCS on the first cycle with `rx_ctrl`=0; that byte is FCS byte 0.
- FCS captures exactly 4 bytes, counted 0..3. Then → CHECK.
- CHECK lasts one cycle and evaluates the frame:
  - CRC: IEEE 802.3, reflected, init 0xFFFFFFFF, run over all bytes including the FCS. The frame is good iff the residue equals 0xDEBB20E3.
  - Length: must be within 64..1518.
  - If both pass and a descriptor slot is free: commit by setting `commit_ptr` ← `wr_ptr` and pushing the descriptor.
  - Otherwise: roll back `wr_ptr` ← `commit_ptr` and increment exactly one counter, in priority order len > fcs > ovf.
  - CHECK → IDLE.
- Buffer full while in DATA/FCS:
  - Drop the byte, roll back `wr_ptr`, increment `drop_ovf_cnt`, → DISCARD.
- `rx_ctrl`=1 during FCS (no gap between frames):
  - Roll back, increment `drop_len_cnt`, → DISCARD.
- `link_sync` falls mid-frame:
  - Roll back, no counter change, → DISCARD.
- DISCARD → IDLE on the first cycle with `rx_ctrl`=0.
- MAC bytes are captured into the in-flight descriptor at byte indices 0..11.
- Read side:
  - The `hdr_valid`&&`hdr_ready` handshake pops the descriptor and arms the reader with `hdr_len`.
  - Each `rd_en` while armed reads one byte at `rd_ptr`.
  - `rd_en` when unarmed, or beyond `hdr_len`, is ignored: the pointer does not move.
  - Free space is `2**N - (commit-relative occupancy from rd_ptr to wr_ptr)`.
- Pointers are N+1 bits and wrap naturally. The buffer is full when the pointers are equal in their low N bits and differ in the MSB.

## Timing
- Reset values:
  - All pointers 0, descriptor FIFO empty, FSM in IDLE, reader unarmed.
  - `hdr_valid`=0, `rd_data`=0, `rd_last`=0, all counters 0.
- Reset mid-frame or mid-read loses all buffered and in-flight data.
- The last FCS byte is sampled at cycle T. CHECK runs at T+1. `hdr_valid`=1 at T+2 at the earliest.
- Header fields are stable while `hdr_valid`=1 and `hdr_ready`=0.
- `rd_data`/`rd_last` are valid on the cycle after `rd_en` (1-cycle RAM latency). Back-to-back `rd_en` gives one byte per cycle.
- A handshake and `rd_en` may occur in the same cycle. That `rd_en` reads byte 0 of the newly accepted frame only if the reader is not still armed for the previous frame.
- Space freed by a read is visible to the writer on the next cycle.
- Commit and read in the same cycle are both performed.

## Structure
- `switch_pkg` holds:
  - `MIN_FRAME_LEN`=64, `MAX_FRAME_LEN`=1518, `CRC_RESIDUE`=32'hDEBB20E3.
  - The `rx_desc_t` struct: dst, src, len.
  - The RX FSM state enum.
- Sub-module `crc32_d8`: combinational next-CRC for one byte. It is shared with the TX FCS generator.
- Buffer RAM is inferred inside this block.

## Test plan
- 64-byte frame 00 10 A4 7B EA 80 00 12…, FCS E6 C5 3D B2 → `hdr_dst_mac`=0010A47BEA80, `hdr_src_mac`=001234567890, `hdr_len`=64. Reading 64 bytes returns the input exactly, with `rd_last` on B2.
- Same frame with byte 15 changed 00→10 → no `hdr_valid`, `drop_fcs_cnt`=1. A following good frame is delivered intact.
- 114-byte frame, FCS B4 38 56 E5 → `hdr_len`=114, `hdr_dst_mac`=08004500002E.
- 40-byte frame with valid CRC → `drop_len_cnt`=1, buffer occupancy unchanged.
- Five good 64-byte frames with `hdr_ready`=0 → four descriptors held, `drop_ovf_cnt`=1. Draining all four gives frames in order.
- `reset` pulsed at byte 30 of a frame, then a good frame is sent → only the second frame appears, with all counters 0.
